// File: rtl/gb_result_drain.sv
// gb_result_drain: reads a run of global-buffer lines after a layer completes
// and streams every line to the host as a valid/ready byte stream, element 0
// of each line first. The next line is fetched while the current one drains,
// so with the host always ready the stream carries one byte every cycle.
module gb_result_drain #(
  parameter int DATA_WIDTH            = 8,
  parameter int length                = 16,
  parameter int global_buf_addr_width = 16
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [global_buf_addr_width-1:0]     INIT_OUTPUT_ADDR,
  input  logic [12:0]                          N_LINES,
  output logic [global_buf_addr_width-1:0]     gb_raddr,
  output logic                                 gb_rd_en,
  input  logic [DATA_WIDTH*length-1:0]         gb_dout,
  output logic [DATA_WIDTH-1:0]                dout,
  output logic                                 dout_valid,
  input  logic                                 dout_ready,
  output logic                                 dout_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int              IDX_W    = (length > 1) ? $clog2(length) : 1;
  localparam int              LINE_W   = DATA_WIDTH * length;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(length - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                           r_state;
  logic                             r_busy;
  logic                             r_done;
  logic [global_buf_addr_width-1:0] r_base;
  logic [12:0]                      r_nlines;
  logic [12:0]                      r_req_cnt;
  logic                             r_inflight;

  logic [LINE_W-1:0]                r_cur;
  logic [IDX_W-1:0]                 r_byte_idx;
  logic                             r_cur_valid;
  logic [LINE_W-1:0]                r_nxt;
  logic                             r_nxt_valid;
  logic [12:0]                      r_load_cnt;

  logic                             w_xfer;
  logic                             w_final;
  logic                             w_last;
  logic                             w_end;
  logic                             w_rd;
  logic                             w_accept;

  // Handshake decode: byte transfer, end of the current line, end of the
  // whole drain, and whether a new line read may be launched this cycle.
  // A read is allowed once the holding register is free or is about to be
  // emptied into cur on this very edge, which keeps the stream gap-free.
  always_comb begin
    w_xfer   = r_cur_valid & dout_ready;
    w_final  = w_xfer & (r_byte_idx == LAST_IDX);
    w_last   = r_cur_valid & (r_byte_idx == LAST_IDX) & (r_load_cnt == r_nlines);
    w_end    = w_xfer & w_last;
    w_rd     = (r_state == RUN) & (r_req_cnt < r_nlines) & ~r_inflight &
               (~r_nxt_valid | w_final);
    w_accept = (r_state == IDLE) & start;
  end

  assign gb_rd_en   = w_rd;
  assign gb_raddr   = r_base + global_buf_addr_width'(r_req_cnt);
  assign dout       = r_cur[DATA_WIDTH-1:0];
  assign dout_valid = r_cur_valid;
  assign dout_last  = w_last;
  assign busy       = r_busy;
  assign done       = r_done;

  // Control FSM: latches the drain parameters on start, counts issued reads,
  // remembers the single outstanding read, and produces busy/done.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_base     <= '0;
      r_nlines   <= '0;
      r_req_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_inflight <= 1'b0;
          r_done     <= 1'b0;
          if (start) begin
            r_base    <= INIT_OUTPUT_ADDR;
            r_nlines  <= N_LINES;
            r_req_cnt <= '0;
            if (N_LINES != 13'd0) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_inflight <= w_rd;
          if (w_rd) begin
            r_req_cnt <= r_req_cnt + 13'd1;
          end
          if (w_end) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_inflight <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_inflight <= 1'b0;
        end
      endcase
    end
  end

  // Line buffering: cur shifts one element out per transfer; returning read
  // data fills cur when it is empty or finishing, otherwise it parks in nxt.
  // When cur finishes, a parked line in nxt takes priority for cur and any
  // data returning on that same edge goes into the freed holding register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_cur       <= '0;
      r_byte_idx  <= '0;
      r_cur_valid <= 1'b0;
      r_nxt       <= '0;
      r_nxt_valid <= 1'b0;
      r_load_cnt  <= '0;
    end else if (w_accept) begin
      r_byte_idx  <= '0;
      r_cur_valid <= 1'b0;
      r_nxt_valid <= 1'b0;
      r_load_cnt  <= '0;
    end else if (w_final) begin
      r_byte_idx <= '0;
      if (r_nxt_valid) begin
        r_cur       <= r_nxt;
        r_cur_valid <= 1'b1;
        r_load_cnt  <= r_load_cnt + 13'd1;
        r_nxt_valid <= r_inflight;
        if (r_inflight) begin
          r_nxt <= gb_dout;
        end
      end else if (r_inflight) begin
        r_cur       <= gb_dout;
        r_cur_valid <= 1'b1;
        r_load_cnt  <= r_load_cnt + 13'd1;
      end else begin
        r_cur_valid <= 1'b0;
      end
    end else if (w_xfer) begin
      r_cur      <= r_cur >> DATA_WIDTH;
      r_byte_idx <= r_byte_idx + IDX_W'(1);
      if (r_inflight) begin
        r_nxt       <= gb_dout;
        r_nxt_valid <= 1'b1;
      end
    end else if (r_inflight) begin
      if (!r_cur_valid) begin
        r_cur       <= gb_dout;
        r_cur_valid <= 1'b1;
        r_byte_idx  <= '0;
        r_load_cnt  <= r_load_cnt + 13'd1;
      end else begin
        r_nxt       <= gb_dout;
        r_nxt_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gb_result_drain.sv
// tb_gb_result_drain: drives drains of various sizes against a simple
// global-buffer memory and checks the byte stream, reads, busy and done
// against a queue-based model of what the host must receive.
module tb_gb_result_drain;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [15:0]  initAddr;
  logic [12:0]  nLines;
  logic [15:0]  gbRaddr;
  logic         gbRdEn;
  logic [127:0] gbDout = '0;
  logic [7:0]   dout;
  logic         doutValid;
  logic         doutReady;
  logic         doutLast;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  int          readyMode = 0;
  int          seed = 0;
  logic [3:0]  readyPattern = 4'b1001;
  int          patPhase = 0;

  logic [7:0]  expQ[$];
  logic        expBusy = 1'b0;
  logic        expDone = 1'b0;
  logic        afterReset = 1'b0;
  logic [15:0] mBase = '0;
  int          mN = 0;
  int          readsIssued = 0;
  int          cyc = 0;
  int          firstRd = -1;
  int          firstValid = -1;
  int          lastXfer = -1;
  int          bytesThisDrain = 0;
  logic [7:0]  byteLog[$];
  logic [15:0] readLog[$];
  int          doneCount = 0;
  int          startDone = 0;
  logic        prevStall = 1'b0;
  logic [7:0]  prevDout = '0;
  logic        prevLast = 1'b0;

  gb_result_drain #(
    .DATA_WIDTH(8),
    .length(16),
    .global_buf_addr_width(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .INIT_OUTPUT_ADDR(initAddr),
    .N_LINES(nLines),
    .gb_raddr(gbRaddr),
    .gb_rd_en(gbRdEn),
    .gb_dout(gbDout),
    .dout(dout),
    .dout_valid(doutValid),
    .dout_ready(doutReady),
    .dout_last(doutLast),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lineByte(logic [15:0] addr, int k, int s);
    int v;
    v = int'(addr) * 16 + k + s;
    return v[7:0];
  endfunction

  function automatic logic [127:0] lineWord(logic [15:0] addr, int s);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = lineByte(addr, k, s);
    return w;
  endfunction

  function automatic logic [7:0] logByte(int i);
    if (byteLog.size() > i) return byteLog[i];
    return 8'hxx;
  endfunction

  function automatic logic [15:0] logRead(int i);
    if (readLog.size() > i) return readLog[i];
    return 16'hxxxx;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Global-buffer memory: each line's content is a function of its address,
  // returned one cycle after the read strobe.
  always @(posedge clk) begin
    if (gbRdEn) gbDout <= lineWord(gbRaddr, seed);
  end

  // Host ready driver: always ready, a fixed 1-0-0-1 pattern, or random.
  initial begin
    doutReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: doutReady = 1'b1;
        1: begin
          doutReady = readyPattern[patPhase];
          patPhase = (patPhase + 1) % 4;
        end
        default: doutReady = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Compare process: checks the outputs every cycle against the model, then
  // advances the model to what the next cycle must show.
  always @(negedge clk) begin
    logic        xfer;
    logic        isLast;
    logic        idle;
    logic [15:0] expAddr;
    cyc++;
    if (afterReset) begin
      checkOutput("resetValid", doutValid, 0);
      checkOutput("resetDout", dout, 0);
      checkOutput("resetLast", doutLast, 0);
      checkOutput("resetRdEn", gbRdEn, 0);
      checkOutput("resetRaddr", gbRaddr, 0);
    end
    checkOutput("busy", busy, expBusy);
    checkOutput("done", done, expDone);
    if (done === 1'b1) doneCount++;
    if (prevStall) begin
      checkOutput("stallValid", doutValid, 1);
      checkOutput("stallDout", dout, prevDout);
      checkOutput("stallLast", doutLast, prevLast);
    end
    if (doutValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedValid", doutValid, 0);
      end else begin
        checkOutput("dout", dout, expQ[0]);
        checkOutput("doutLast", doutLast, (expQ.size() == 1) ? 1 : 0);
      end
      if (firstValid < 0) firstValid = cyc;
    end else begin
      checkOutput("doutLastIdle", doutLast, 0);
    end
    xfer   = (doutValid === 1'b1) && (doutReady === 1'b1);
    isLast = xfer && (expQ.size() == 1);
    if (xfer && expQ.size() > 0) begin
      byteLog.push_back(dout);
      void'(expQ.pop_front());
      bytesThisDrain++;
      lastXfer = cyc;
    end
    prevStall = (doutValid === 1'b1) && (doutReady !== 1'b1);
    prevDout  = dout;
    prevLast  = doutLast;
    if (gbRdEn === 1'b1) begin
      if (!expBusy || readsIssued >= mN) begin
        checkOutput("extraRead", gbRdEn, 0);
      end else begin
        expAddr = mBase + 16'(readsIssued);
        checkOutput("raddr", gbRaddr, expAddr);
      end
      readLog.push_back(gbRaddr);
      readsIssued++;
      if (firstRd < 0) firstRd = cyc;
    end
    afterReset = 1'b0;
    if (rstn === 1'b1) begin
      expQ.delete();
      expBusy    = 1'b0;
      expDone    = 1'b0;
      afterReset = 1'b1;
      prevStall  = 1'b0;
    end else begin
      idle    = !expBusy && !expDone;
      expDone = isLast || (start && idle && nLines == 13'd0);
      if (expBusy && isLast) expBusy = 1'b0;
      else if (start && idle && nLines != 13'd0) expBusy = 1'b1;
      if (start && idle) begin
        mBase          = initAddr;
        mN             = int'(nLines);
        readsIssued    = 0;
        cyc            = 0;
        firstRd        = -1;
        firstValid     = -1;
        lastXfer       = -1;
        bytesThisDrain = 0;
        byteLog.delete();
        readLog.delete();
        for (int l = 0; l < mN; l++)
          for (int k = 0; k < 16; k++)
            expQ.push_back(lineByte(initAddr + 16'(l), k, seed));
      end
    end
  end

  task automatic applyStimulus(logic [15:0] base, int n, int mode);
    readyMode = mode;
    @(posedge clk);
    #1;
    startDone = doneCount;
    initAddr  = base;
    nLines    = 13'(n);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDrainEnd(int budget);
    for (int i = 0; i < budget && doneCount == startDone; i++) @(posedge clk);
    checkOutput("drainDone", (doneCount != startDone) ? 1 : 0, 1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int n;
    rstn     = 1'b1;
    start    = 1'b0;
    initAddr = '0;
    nLines   = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] single line, always ready");
    applyStimulus(16'h0040, 1, 0);
    waitDrainEnd(100);
    checkOutput("t1Reads", readsIssued, 1);
    checkOutput("t1Raddr", logRead(0), 16'h0040);
    checkOutput("t1FirstRd", firstRd, 1);
    checkOutput("t1FirstValid", firstValid, 3);
    checkOutput("t1LastXfer", lastXfer, 18);
    checkOutput("t1Bytes", bytesThisDrain, 16);
    checkOutput("t1Byte0", logByte(0), 8'h00);
    checkOutput("t1Byte15", logByte(15), 8'h0F);

    $display("[TB] back-to-back lines");
    applyStimulus(16'h0040, 4, 0);
    waitDrainEnd(200);
    checkOutput("t2Reads", readsIssued, 4);
    checkOutput("t2Raddr3", logRead(3), 16'h0043);
    checkOutput("t2Bytes", bytesThisDrain, 64);
    checkOutput("t2LastXfer", lastXfer, 66);
    checkOutput("t2Byte63", logByte(63), 8'h3F);

    $display("[TB] backpressure");
    applyStimulus(16'h0040, 2, 1);
    waitDrainEnd(300);
    checkOutput("t3Reads", readsIssued, 2);
    checkOutput("t3Bytes", bytesThisDrain, 32);
    checkOutput("t3Byte31", logByte(31), 8'h1F);

    $display("[TB] zero length");
    applyStimulus(16'h0040, 0, 0);
    waitDrainEnd(10);
    repeat (3) @(posedge clk);
    checkOutput("t4Reads", readsIssued, 0);
    checkOutput("t4Bytes", bytesThisDrain, 0);
    checkOutput("t4NoValid", firstValid, -1);

    $display("[TB] wrap and ignored start");
    applyStimulus(16'hFFFF, 2, 0);
    repeat (10) @(posedge clk);
    #1;
    initAddr = 16'h1234;
    nLines   = 13'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDrainEnd(200);
    checkOutput("t5Reads", readsIssued, 2);
    checkOutput("t5Raddr0", logRead(0), 16'hFFFF);
    checkOutput("t5Raddr1", logRead(1), 16'h0000);
    checkOutput("t5Bytes", bytesThisDrain, 32);
    checkOutput("t5LastXfer", lastXfer, 34);

    $display("[TB] reset mid-drain");
    applyStimulus(16'h0040, 2, 0);
    d0 = doneCount;
    for (int i = 0; i < 100 && bytesThisDrain < 5; i++) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1 rstn = 1'b0;
    repeat (6) @(posedge clk);
    checkOutput("t6NoDone", doneCount, d0);
    applyStimulus(16'h0050, 1, 0);
    waitDrainEnd(100);
    checkOutput("t6Bytes", bytesThisDrain, 16);
    checkOutput("t6LastXfer", lastXfer, 18);
    checkOutput("t6Byte0", logByte(0), 8'h00);

    $display("[TB] random drains");
    for (int r = 0; r < 8; r++) begin
      seed = int'($urandom_range(0, 255));
      n    = int'($urandom_range(1, 4));
      applyStimulus(16'($urandom), n, int'($urandom_range(0, 2)));
      waitDrainEnd(16 * n * 12 + 50);
      checkOutput("rndBytes", bytesThisDrain, 16 * n);
      checkOutput("rndReads", readsIssued, n);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
